uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//   UART receiver, the counterpart of the UART transmit path. Deserialises 8N1 frames
//   (1 start, 8 data LSB-first, 1 stop) from the async rx_in pin. Default rate: 230400 baud
//   from the 100 MHz clk. Hands each byte to the host-link logic via a one-entry
//   valid/ready holding register. Flags framing errors and overruns.
// PARAMETERS
//   CLKS_PER_BIT  434  clk cycles per bit (100 MHz / 230400); must be >= 8
//   HALF_BIT      CLKS_PER_BIT/2  cycles from start-edge detect to start-bit mid-sample
// PORTS
//   clk            in   1  system clock, 100 MHz
//   reset          in   1  asynchronous, active-high reset
//   rx_in          in   1  serial line; asynchronous to clk; idle high
//   rx_data        out  8  received byte; stable while rx_data_valid=1
//   rx_data_valid  out  1  holding register full
//   rx_data_ready  in   1  consumer accepts; transfer when valid & ready at posedge
//   frame_err      out  1  1-cycle pulse: stop bit sampled 0, byte discarded
//   overrun        out  1  1-cycle pulse: new byte completed while holding full & not ready
// BEHAVIOUR
//   Reset values: rx_data=8'h00, rx_data_valid=0, frame_err=0, overrun=0; FSM=IDLE.
//   Counters and bit index=0. Both synchroniser flops=1.
//   Synchroniser: rx_in passes through 2 flops -> rx_s. All FSM decisions use rx_s only.
//   Sample counter: 16 bits. It clears on every state entry.
//   FSM:
//    IDLE: rx_s==0 -> START.
//    START: at cnt==HALF_BIT-1, sample rx_s. 0 -> DATA (bit_idx=0). 1 -> IDLE (glitch
//      rejected, no flag).
//    DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into shreg MSB, shifting right (LSB-first),
//      then bit_idx++. After bit_idx 7 -> STOP.
//    STOP: at cnt==CLKS_PER_BIT-1, sample rx_s. 1 -> deliver shreg, -> IDLE.
//      0 -> frame_err pulse, byte dropped, -> BREAK.
//    BREAK: wait for rx_s==1, then -> IDLE. A held-low line yields exactly one frame_err
//      and no false starts.
//   Sample points: mid-bit, at HALF_BIT + k*CLKS_PER_BIT cycles after the falling edge
//     is seen on rx_s, for k=1..9 (data bits, then stop bit).
//   Delivery: on the cycle after the stop-bit sample, update the holding register:
//    - valid=0, or valid=1 & ready=1: load rx_data=shreg; valid=1.
//    - valid=1 & ready=0: keep the old byte; overrun pulses 1 cycle; new byte lost.
//    - Otherwise, valid & ready at a posedge clears valid.
//   Latency: valid rises 2 (sync) + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the rx_in
//     falling edge, +/-1 cycle for sync phase.
//   Back-to-back frames: STOP -> IDLE occurs at mid-stop-bit. This catches the next start
//     edge with zero idle gap.
//   rx_data_ready is ignored while valid=0. rx_data holds its last value after a transfer.
//   reset mid-frame: immediate return to reset values. Partial byte is discarded. The next
//     falling edge after release starts a fresh frame.
//   frame_err and overrun never assert together. Neither affects rx_data or rx_data_valid.
// TESTING (CLKS_PER_BIT=434; the bench drives rx_in at exactly 434 cycles/bit)
//   1. Byte 0xA5, ready=1 -> rx_data=0xA5; valid high exactly 1 cycle; no error flags.
//   2. rx_in low for 100 cycles, then high -> no valid, no frame_err; FSM back in IDLE.
//   3. Frame 0x3C with stop=0, line held low 20 bit times, then 0x55 -> single frame_err
//      pulse, no valid for 0x3C; later rx_data=0x55 valid.
//   4. ready=0, send 0x11 then 0x22 -> valid held with 0x11; overrun pulse at 0x22
//      delivery; raise ready -> 0x11 transferred, valid drops.
//   5. Bytes 0x00, 0xFF, 0x81 back-to-back, no idle bits, ready=1 -> three valids in
//      order, no flags.
//   6. Assert reset during data bit 4 of 0x96 -> outputs at reset values. Next frame 0x7E
//      received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a one-entry
// valid/ready holding register with framing-error and overrun pulses.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [15:0] LP_HALF_LAST = 16'(HALF_BIT - 1);
    localparam logic [15:0] LP_BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shreg;
    logic        r_deliver;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_frame_err;
    logic        r_overrun;
    logic        w_rx_s;

    assign w_rx_s        = r_sync2;
    assign rx_data       = r_data;
    assign rx_data_valid = r_valid;
    assign frame_err     = r_frame_err;
    assign overrun       = r_overrun;

    // NOTE: all state updates use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order inside this block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_cnt       <= 16'd0;
            r_bit_idx   <= 3'd0;
            r_shreg     <= 8'h00;
            r_deliver   <= 1'b0;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1     <= rx_in;
            r_sync2     <= r_sync1;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_deliver   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt <= 16'd0;
                    if (!w_rx_s) r_state <= S_START;
                end
                S_START: begin
                    if (r_cnt == LP_HALF_LAST) begin
                        r_cnt     <= 16'd0;
                        r_bit_idx <= 3'd0;
                        // A line back high at mid-start is a glitch: drop it silently.
                        r_state   <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == LP_BIT_LAST) begin
                        r_cnt     <= 16'd0;
                        r_shreg   <= {w_rx_s, r_shreg[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == LP_BIT_LAST) begin
                        r_cnt <= 16'd0;
                        if (w_rx_s) begin
                            r_deliver <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_BREAK: begin
                    // Wait out a held-low line so it cannot look like a new start bit.
                    r_cnt <= 16'd0;
                    if (w_rx_s) r_state <= S_IDLE;
                end
                default: begin
                    r_cnt   <= 16'd0;
                    r_state <= S_IDLE;
                end
            endcase

            if (r_deliver) begin
                if (!r_valid || rx_data_ready) begin
                    r_data  <= r_shreg;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: drives 8N1 frames at 434 clk/bit and checks
// delivered bytes, handshake and error pulses against hand-computed values.
module tb_uart_rx_core;

    localparam int CPB = 434;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       frame_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    // Event counters maintained by the monitor only.
    int         fe_cnt   = 0;
    int         ov_cnt   = 0;
    int         vcyc     = 0;
    int         both_cnt = 0;
    logic [7:0] got_q[$];

    int q0, fe0, ov0, v0;

    always #5 clk = ~clk;

    uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_in        (rx_in),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always @(negedge clk) begin
        if (rx_data_valid) vcyc <= vcyc + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (frame_err && overrun) both_cnt <= both_cnt + 1;
        if (rx_data_valid && rx_data_ready) got_q.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        wait_neg(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic snap();
        q0  = got_q.size();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        v0  = vcyc;
    endtask

    function automatic logic [7:0] got_at(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 8'hxx;
    endfunction

    initial begin
        reset         = 1'b1;
        rx_in         = 1'b1;
        rx_data_ready = 1'b0;
        wait_neg(5);
        check("reset_data", 32'(rx_data), 32'h00);
        check("reset_valid", 32'(rx_data_valid), 32'd0);
        check("reset_fe", 32'(frame_err), 32'd0);
        check("reset_ov", 32'(overrun), 32'd0);
        reset = 1'b0;
        wait_neg(10);

        // 1: single byte with ready held high
        rx_data_ready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1);
        wait_neg(20);
        check("t1_count", 32'(got_q.size() - q0), 32'd1);
        check("t1_byte", 32'(got_at(q0)), 32'hA5);
        check("t1_valid_cycles", 32'(vcyc - v0), 32'd1);
        check("t1_fe", 32'(fe_cnt - fe0), 32'd0);
        check("t1_ov", 32'(ov_cnt - ov0), 32'd0);

        // 2: short low glitch (shorter than half a bit) is rejected
        snap();
        rx_in = 1'b0;
        wait_neg(100);
        rx_in = 1'b1;
        wait_neg(2 * CPB);
        check("t2_count", 32'(got_q.size() - q0), 32'd0);
        check("t2_fe", 32'(fe_cnt - fe0), 32'd0);

        // 3: bad stop bit, long break, then a good frame
        snap();
        send_frame(8'h3C, 1'b0);
        wait_neg(20 * CPB);
        rx_in = 1'b1;
        wait_neg(2 * CPB);
        check("t3_fe_after_break", 32'(fe_cnt - fe0), 32'd1);
        check("t3_no_byte", 32'(got_q.size() - q0), 32'd0);
        send_frame(8'h55, 1'b1);
        wait_neg(20);
        check("t3_fe_total", 32'(fe_cnt - fe0), 32'd1);
        check("t3_count", 32'(got_q.size() - q0), 32'd1);
        check("t3_byte", 32'(got_at(q0)), 32'h55);

        // 4: overrun while consumer stalls
        rx_data_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_neg(20);
        check("t4_valid_held", 32'(rx_data_valid), 32'd1);
        check("t4_data_held", 32'(rx_data), 32'h11);
        check("t4_ov", 32'(ov_cnt - ov0), 32'd1);
        check("t4_fe", 32'(fe_cnt - fe0), 32'd0);
        check("t4_no_xfer", 32'(got_q.size() - q0), 32'd0);
        @(posedge clk);
        #1 rx_data_ready = 1'b1;
        wait_neg(3);
        check("t4_xfer_count", 32'(got_q.size() - q0), 32'd1);
        check("t4_xfer_byte", 32'(got_at(q0)), 32'h11);
        check("t4_valid_drop", 32'(rx_data_valid), 32'd0);
        check("t4_data_kept", 32'(rx_data), 32'h11);

        // 5: three back-to-back frames, zero idle gap
        snap();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        wait_neg(20);
        check("t5_count", 32'(got_q.size() - q0), 32'd3);
        check("t5_byte0", 32'(got_at(q0)), 32'h00);
        check("t5_byte1", 32'(got_at(q0 + 1)), 32'hFF);
        check("t5_byte2", 32'(got_at(q0 + 2)), 32'h81);
        check("t5_valid_cycles", 32'(vcyc - v0), 32'd3);
        check("t5_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

        // 6: reset in the middle of data bit 4 of 0x96, then a clean frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h96 >> i));
        rx_in = 1'b1;
        wait_neg(200);
        reset = 1'b1;
        #1;
        check("t6_reset_data", 32'(rx_data), 32'h00);
        check("t6_reset_valid", 32'(rx_data_valid), 32'd0);
        check("t6_reset_fe", 32'(frame_err), 32'd0);
        check("t6_reset_ov", 32'(overrun), 32'd0);
        wait_neg(3 * CPB);
        reset = 1'b0;
        wait_neg(20);
        snap();
        send_frame(8'h7E, 1'b1);
        wait_neg(20);
        check("t6_count", 32'(got_q.size() - q0), 32'd1);
        check("t6_byte", 32'(got_at(q0)), 32'h7E);
        check("t6_fe", 32'(fe_cnt - fe0), 32'd0);

        check("fe_ov_exclusive", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
